// File: rtl/interim_fetch_pkg.sv
// rtl/interim_fetch_pkg.sv - shared types and defaults for the interim operand fetch sequencer
package interim_fetch_pkg;

  localparam int ADDR_LEN_DEF  = 6;
  localparam int DATA_LEN_DEF  = 32;
  localparam int RETRY_MAX_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_CHECK_A = 3'd2,
    ST_ISSUE_B = 3'd3,
    ST_CHECK_B = 3'd4,
    ST_OUT     = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/interim_operand_fetch.sv
// rtl/interim_operand_fetch.sv - interim buffer read sequencer feeding ALU operands with RAW retry
module interim_operand_fetch
  import interim_fetch_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_DEF,
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr_a,
  input  logic [ADDR_LEN-1:0] req_addr_b,
  input  logic                req_two,
  output logic                buf_rd_en,
  output logic [ADDR_LEN-1:0] buf_rd_addr,
  output logic                buf_stall,
  input  logic [DATA_LEN-1:0] buf_data,
  input  logic                buf_data_v,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_LEN-1:0] op_a,
  output logic [DATA_LEN-1:0] op_b,
  output logic                op_err
);

  localparam int CNT_W = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_MAX - 1);

  fetch_state_e        state_q, state_d;
  logic [ADDR_LEN-1:0] addr_a_q, addr_a_d;
  logic [ADDR_LEN-1:0] addr_b_q, addr_b_d;
  logic                two_q, two_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_LEN-1:0] op_a_q, op_a_d;
  logic [DATA_LEN-1:0] op_b_q, op_b_d;
  logic                expire;

  // An unwritten entry on the last permitted attempt gives up on this operand
  assign expire = !buf_data_v && (cnt_q == RETRY_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      two_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      two_q    <= two_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    two_d    = two_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          two_d    = req_two;
          cnt_d    = '0;
          err_d    = 1'b0;
          op_a_d   = '0;
          op_b_d   = '0;
          state_d  = ST_ISSUE_A;
        end
      end
      ST_ISSUE_A: if (!stall) state_d = ST_CHECK_A;
      ST_ISSUE_B: if (!stall) state_d = ST_CHECK_B;
      ST_CHECK_A: begin
        if (buf_data_v || expire) begin
          op_a_d  = buf_data_v ? buf_data : '0;
          err_d   = err_q | expire;
          cnt_d   = '0;
          state_d = two_q ? ST_ISSUE_B : ST_OUT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ISSUE_A;
        end
      end
      ST_CHECK_B: begin
        if (buf_data_v || expire) begin
          op_b_d  = buf_data_v ? buf_data : '0;
          err_d   = err_q | expire;
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ISSUE_B;
        end
      end
      ST_OUT: if (op_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign buf_rd_en   = ((state_q == ST_ISSUE_A) || (state_q == ST_ISSUE_B)) && !stall;
  assign buf_rd_addr = (state_q == ST_ISSUE_B) ? addr_b_q : addr_a_q;
  assign buf_stall   = stall;
  assign op_valid    = (state_q == ST_OUT);
  assign op_err      = (state_q == ST_OUT) && err_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;

endmodule

// File: tb/tb_interim_operand_fetch.sv
// tb/tb_interim_operand_fetch.sv - self-checking bench with interim buffer model and timing reference
module tb_interim_operand_fetch;

  localparam int RM = 4;

  logic        clk = 1'b0;
  logic        rstn, stall, req_valid, req_ready, req_two;
  logic [5:0]  req_addr_a, req_addr_b, buf_rd_addr;
  logic        buf_rd_en, buf_stall, buf_data_v, op_valid, op_ready, op_err;
  logic [31:0] buf_data, op_a, op_b;

  int checks = 0;
  int errors = 0;

  interim_operand_fetch #(.ADDR_LEN(6), .DATA_LEN(32), .RETRY_MAX(RM)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_two(req_two),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_stall(buf_stall),
    .buf_data(buf_data), .buf_data_v(buf_data_v),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_err(op_err)
  );

  always #5 clk = ~clk;

  // Interim buffer model: written flags, 1-cycle read latency, same-cycle write forwarding
  logic [31:0] mem [64];
  bit          wrf [64];
  int          cyc = 0;
  int          rd_n = 0;
  logic [5:0]  rd_log [256];
  bit          sched_en [2];
  int          sched_cyc [2];
  logic [5:0]  sched_addr [2];
  logic [31:0] sched_data [2];
  logic        pw_en = 1'b0;
  logic        pw_v = 1'b0;
  logic [5:0]  pw_addr = '0;
  logic [31:0] pw_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pw_en) begin
      mem[pw_addr] <= pw_data;
      wrf[pw_addr] <= pw_v;
    end
    if (buf_rd_en) begin
      buf_data   <= mem[buf_rd_addr];
      buf_data_v <= wrf[buf_rd_addr];
      rd_log[rd_n % 256] <= buf_rd_addr;
      rd_n <= rd_n + 1;
    end
    for (int i = 0; i < 2; i++) begin
      if (sched_en[i] && (cyc + 1 == sched_cyc[i])) begin
        mem[sched_addr[i]] <= sched_data[i];
        wrf[sched_addr[i]] <= 1'b1;
        if (buf_rd_en && buf_rd_addr == sched_addr[i]) begin
          buf_data   <= sched_data[i];
          buf_data_v <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] a, input logic [31:0] d, input bit v);
    pw_en = 1'b1; pw_addr = a; pw_data = d; pw_v = v;
    tick();
    pw_en = 1'b0;
  endtask

  // Reads performed for one operand whose first read is in cycle r0 and whose entry
  // becomes visible to reads in cycle >= w (w=0 already written, w<0 never written).
  function automatic int n_reads(input int w, input int r0, output bit ok);
    int j;
    if (w == 0) begin ok = 1'b1; return 1; end
    if (w < 0) begin ok = 1'b0; return RM; end
    j = (w <= r0) ? 0 : (w - r0 + 1) / 2;
    ok = (j < RM);
    return ok ? j + 1 : RM;
  endfunction

  task automatic wait_out(input int t0, input int exp_cyc, input string tag);
    for (int k = 0; k < 200 && !op_valid; k++) tick();
    chk({tag, "_timeout"}, 32'(op_valid), 32'd1);
    chk({tag, "_cycle"}, 32'(cyc - t0 + 1), 32'(exp_cyc));
  endtask

  task automatic do_req(input logic [5:0] a, input logic [5:0] b, input bit two,
                        input int wa, input int wb, input logic [31:0] da,
                        input logic [31:0] db, input int rdy_dly, input string tag);
    bit okA, okB;
    int nA, nB, t0, base;
    logic [31:0] ea, eb;
    logic ee;
    put(a, (wa == 0) ? da : ~da, wa == 0);
    put(b, (wb == 0) ? db : ~db, wb == 0);
    nA = n_reads(wa, 1, okA);
    okB = 1'b1;
    nB = two ? n_reads(wb, 2 * nA + 1, okB) : 0;
    ea = okA ? da : 32'd0;
    eb = (two && okB) ? db : 32'd0;
    ee = !okA || (two && !okB);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    t0 = cyc + 1;
    base = rd_n;
    sched_en[0] = (wa > 0); sched_cyc[0] = t0 + wa; sched_addr[0] = a; sched_data[0] = da;
    sched_en[1] = (wb > 0) && two; sched_cyc[1] = t0 + wb; sched_addr[1] = b; sched_data[1] = db;
    req_valid = 1'b1; req_addr_a = a; req_addr_b = b; req_two = two;
    tick();
    req_valid = 1'b0;
    wait_out(t0, 2 * (nA + nB) + 1, tag);
    chk({tag, "_op_a"}, op_a, ea);
    chk({tag, "_op_b"}, op_b, eb);
    chk({tag, "_op_err"}, 32'(op_err), 32'(ee));
    chk({tag, "_nreads"}, 32'(rd_n - base), 32'(nA + nB));
    for (int i = 0; i < nA + nB; i++)
      chk({tag, "_rd_addr"}, 32'(rd_log[(base + i) % 256]), 32'((i < nA) ? a : b));
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(op_valid), 32'd1);
      chk({tag, "_hold_a"}, op_a, ea);
      chk({tag, "_hold_b"}, op_b, eb);
      chk({tag, "_hold_err"}, 32'(op_err), 32'(ee));
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    sched_en[0] = 1'b0; sched_en[1] = 1'b0;
    chk({tag, "_valid_drop"}, 32'(op_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int t0, base, m, w [2];
    logic [31:0] d3, d9;
    logic [5:0] ra;
    rstn = 1'b0; stall = 1'b0; req_valid = 1'b0; op_ready = 1'b0; req_two = 1'b0;
    req_addr_a = '0; req_addr_b = '0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    stall = 1'b1;
    #1;
    chk("buf_stall_hi", 32'(buf_stall), 32'd1);
    stall = 1'b0;
    #1;
    chk("buf_stall_lo", 32'(buf_stall), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    do_req(6'd5, 6'd6, 1'b0, 0, -1, 32'h1234, 32'h0, 0, "single");
    do_req(6'd3, 6'd9, 1'b1, 0, 0, 32'h7, 32'hA, 4, "pair_hold");
    do_req(6'd12, 6'd13, 1'b0, 6, -1, 32'h55, 32'h0, 0, "raw_wait");
    do_req(6'd20, 6'd21, 1'b0, -1, -1, 32'hDEAD, 32'h0, 0, "timeout");
    do_req(6'd30, 6'd31, 1'b1, 0, -1, 32'h11, 32'h22, 1, "timeout_b");

    // Stall held across the operand B issue cycle
    d3 = $urandom; d9 = $urandom;
    put(6'd3, d3, 1'b1);
    put(6'd9, d9, 1'b1);
    t0 = cyc + 1;
    base = rd_n;
    req_valid = 1'b1; req_addr_a = 6'd3; req_addr_b = 6'd9; req_two = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      #1;
      chk("stall_rd_en", 32'(buf_rd_en), 32'd0);
      chk("stall_buf_stall", 32'(buf_stall), 32'd1);
    end
    tick();
    stall = 1'b0;
    #1;
    chk("unstall_rd_en", 32'(buf_rd_en), 32'd1);
    chk("unstall_rd_addr", 32'(buf_rd_addr), 32'd9);
    tick();
    wait_out(t0, 8, "stall");
    chk("stall_op_a", op_a, d3);
    chk("stall_op_b", op_b, d9);
    chk("stall_nreads", 32'(rd_n - base), 32'd2);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Asynchronous reset while waiting on operand A data
    put(6'd7, 32'hCAFE, 1'b1);
    req_valid = 1'b1; req_addr_a = 6'd7; req_addr_b = 6'd8; req_two = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("arst_rd_addr", 32'(buf_rd_addr), 32'd0);
    chk("arst_op_valid", 32'(op_valid), 32'd0);
    chk("arst_op_a", op_a, 32'd0);
    chk("arst_op_b", op_b, 32'd0);
    chk("arst_op_err", 32'(op_err), 32'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_idle", 32'(op_valid), 32'd0);
    end
    do_req(6'd7, 6'd8, 1'b0, 0, -1, 32'hBEEF, 32'h0, 0, "after_rst");

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 2; k++) begin
        m = $urandom_range(2, 0);
        w[k] = (m == 0) ? 0 : (m == 1) ? int'($urandom_range(9, 1)) : -1;
      end
      ra = 6'($urandom_range(31, 0));
      do_req(ra, ra ^ 6'h20, 1'($urandom_range(1, 0)), w[0], w[1], $urandom, $urandom,
             int'($urandom_range(2, 0)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
